// File: rtl/result_serializer.sv
// Drains an N x N result matrix from a synchronous-read memory to a UART transmitter,
// row-major word order, each RES_W-bit word sent as bytes MSB first via start/busy handshake.
module result_serializer #(
    parameter int N      = 3,
    parameter int RES_W  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [RES_W-1:0]  res_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);
    localparam int BYTES  = RES_W / 8;
    localparam int WORDS  = N * N;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LOAD    = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    state_t            r_state,    w_state;
    logic [ADDR_W-1:0] r_word_idx, w_word_idx;
    logic [BIDX_W-1:0] r_byte_idx, w_byte_idx;
    logic [RES_W-1:0]  r_shreg,    w_shreg;
    logic [7:0]        r_tx_data,  w_tx_data;
    logic              r_tx_start, w_tx_start;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;

    // State and output registers; reset abandons any partial byte stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_word_idx <= {ADDR_W{1'b0}};
            r_byte_idx <= {BIDX_W{1'b0}};
            r_shreg    <= {RES_W{1'b0}};
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_word_idx <= w_word_idx;
            r_byte_idx <= w_byte_idx;
            r_shreg    <= w_shreg;
            r_tx_data  <= w_tx_data;
            r_tx_start <= w_tx_start;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state    = r_state;
        w_word_idx = r_word_idx;
        w_byte_idx = r_byte_idx;
        w_shreg    = r_shreg;
        w_tx_data  = r_tx_data;
        w_tx_start = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_done high means this is the cycle right after finishing: a start here is dropped
                if (start && !r_done) begin
                    w_state    = S_READ;
                    w_word_idx = {ADDR_W{1'b0}};
                    w_busy     = 1'b1;
                end else begin
                    w_state    = S_IDLE;
                end
            end
            S_READ: begin
                w_state = S_LOAD;
            end
            S_LOAD: begin
                w_shreg    = res_data;
                w_byte_idx = {BIDX_W{1'b0}};
                // Launch the first byte straight from memory data when the UART is free,
                // so the pulse is visible in the cycle the send step would occupy
                if (!tx_busy) begin
                    w_tx_data  = res_data[RES_W-1 -: 8];
                    w_tx_start = 1'b1;
                    w_state    = S_WAIT_HI;
                end else begin
                    w_state    = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_tx_data  = r_shreg[RES_W-1 -: 8];
                    w_tx_start = 1'b1;
                    w_state    = S_WAIT_HI;
                end else begin
                    w_state    = S_SEND;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    w_state = S_WAIT_LO;
                end else begin
                    w_state = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_shreg    = r_shreg << 8;
                        w_byte_idx = r_byte_idx + BIDX_W'(1);
                        w_state    = S_SEND;
                    end else if (r_word_idx != LAST_WORD) begin
                        w_word_idx = r_word_idx + ADDR_W'(1);
                        w_state    = S_READ;
                    end else begin
                        w_done     = 1'b1;
                        w_busy     = 1'b0;
                        w_state    = S_IDLE;
                    end
                end else begin
                    w_state = S_WAIT_LO;
                end
            end
            default: begin
                w_state    = S_IDLE;
                w_busy     = 1'b0;
            end
        endcase
    end

    assign res_addr = r_word_idx;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: two serializers (N=2/16-bit and N=1/32-bit) with memory and UART busy models.
module tb_result_serializer;
    localparam int BUSY_CYC = 10;
    localparam int TMO      = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic [3:0]  addr_a;
    logic [15:0] rdata_a;
    logic [7:0]  txd_a;
    logic        txs_a, txb_a, bsy_a, dn_a;

    logic        start_b = 1'b0;
    logic [0:0]  addr_b;
    logic [31:0] rdata_b;
    logic [7:0]  txd_b;
    logic        txs_b, txb_b, bsy_b, dn_b;

    logic [1:0]  mdl_busy = 2'b00;
    logic        force_busy = 1'b0;
    assign txb_a = mdl_busy[0] | force_busy;
    assign txb_b = mdl_busy[1];

    logic [15:0] mem_a [16];
    logic [31:0] mem_b [2];

    result_serializer #(.N(2), .RES_W(16), .ADDR_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .res_addr(addr_a), .res_data(rdata_a),
        .tx_data(txd_a), .tx_start(txs_a), .tx_busy(txb_a), .busy(bsy_a), .done(dn_a)
    );

    result_serializer #(.N(1), .RES_W(32), .ADDR_W(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .res_addr(addr_b), .res_data(rdata_b),
        .tx_data(txd_b), .tx_start(txs_b), .tx_busy(txb_b), .busy(bsy_b), .done(dn_b)
    );

    // Synchronous-read result memories
    always_ff @(posedge clk) begin
        rdata_a <= mem_a[addr_a];
        rdata_b <= mem_b[addr_b];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         busy_cnt   [2] = '{0, 0};
    int         starts     [2] = '{0, 0};
    int         bytes_done [2] = '{0, 0};
    int         exp_total  [2] = '{0, 0};
    int         dones      [2] = '{0, 0};
    logic       prev_s     [2] = '{1'b0, 1'b0};
    logic [7:0] cur_byte   [2] = '{8'h00, 8'h00};

    task automatic mon_step(input int d, input logic s, input logic b, input logic [7:0] data,
                            input logic dn_i, input logic [3:0] addr);
        int qsz;
        int last;
        logic [7:0] exp;
        if (!rst) begin
            busy_cnt[d] = 0;
            mdl_busy[d] = 1'b0;
            prev_s[d]   = 1'b0;
            return;
        end
        last = (d == 0) ? 3 : 0;
        if (s) begin
            starts[d]++;
            check("start_while_busy", 32'(b), 32'd0);
            check("start_consecutive", 32'(prev_s[d]), 32'd0);
            check("addr_in_range", 32'(addr <= 4'(last)), 32'd1);
            qsz = (d == 0) ? q0.size() : q1.size();
            if (qsz == 0) begin
                check("sb_underflow", 32'(qsz), 32'd1);
            end else begin
                if (d == 0) exp = q0.pop_front();
                else        exp = q1.pop_front();
                check("tx_byte", 32'(data), 32'(exp));
            end
            cur_byte[d] = data;
            mdl_busy[d] = 1'b1;
            busy_cnt[d] = BUSY_CYC;
        end else if (busy_cnt[d] > 0) begin
            busy_cnt[d]--;
            if (busy_cnt[d] == 0) begin
                check("tx_data_hold", 32'(data), 32'(cur_byte[d]));
                mdl_busy[d] = 1'b0;
                bytes_done[d]++;
            end
        end
        if (dn_i) begin
            dones[d]++;
            qsz = (d == 0) ? q0.size() : q1.size();
            check("done_byte_count", 32'(bytes_done[d]), 32'(exp_total[d]));
            check("sb_empty_at_done", 32'(qsz), 32'd0);
        end
        prev_s[d] = s;
    endtask

    // UART busy model and scoreboard monitor, sampled on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, txs_a, txb_a, txd_a, dn_a, addr_a);
            mon_step(1, txs_b, txb_b, txd_b, dn_b, {3'b000, addr_b});
        end
    end

    task automatic push_a();
        bytes_done[0] = 0;
        exp_total[0]  = 8;
        for (int w = 0; w < 4; w++) begin
            q0.push_back(mem_a[w][15:8]);
            q0.push_back(mem_a[w][7:0]);
        end
    endtask

    task automatic push_b();
        bytes_done[1] = 0;
        exp_total[1]  = 4;
        for (int k = 3; k >= 0; k--) q1.push_back(mem_b[0][k*8 +: 8]);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while (((d == 0) ? dn_a : dn_b) == 1'b0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 32'(t < TMO), 32'd1);
    endtask

    task automatic wait_starts(input int n);
        int t;
        t = 0;
        while (starts[0] < n && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("byte_start_timeout", 32'(t < TMO), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int s0;
        int t;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'h0000;
        mem_a[0] = 16'h1234;
        mem_a[1] = 16'hABCD;
        mem_a[2] = 16'h0001;
        mem_a[3] = 16'hFFFF;
        mem_b[0] = 32'hDEADBEEF;
        mem_b[1] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check("rst_addr_a", 32'(addr_a), 32'd0);
        check("rst_txd_a", 32'(txd_a), 32'd0);
        check("rst_txs_a", 32'(txs_a), 32'd0);
        check("rst_busy_a", 32'(bsy_a), 32'd0);
        check("rst_done_a", 32'(dn_a), 32'd0);
        check("rst_busy_b", 32'(bsy_b), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full stream with start-to-first-byte latency
        push_a();
        d0 = dones[0];
        start_a = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start_a = 1'b0;
                check("busy_after_start", 32'(bsy_a), 32'd1);
            end
        end while (!txs_a && lat < 50);
        check("first_start_latency", 32'(lat), 32'd3);
        wait_done(0);
        repeat (5) @(negedge clk);
        check("single_done_run1", 32'(dones[0] - d0), 32'd1);
        check("busy_low_after_run1", 32'(bsy_a), 32'd0);
        check("addr_last_run1", 32'(addr_a), 32'd3);

        // Start re-pulsed during byte 3, then a start coincident with done
        push_a();
        d0 = dones[0];
        s0 = starts[0];
        pulse_a();
        wait_starts(s0 + 3);
        pulse_a();
        wait_done(0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        check("single_done_repulse", 32'(dones[0] - d0), 32'd1);
        check("byte_count_repulse", 32'(starts[0] - s0), 32'd8);
        check("start_at_done_ignored", 32'(bsy_a), 32'd0);

        // UART busy held high before the first byte
        force_busy = 1'b1;
        push_a();
        d0 = dones[0];
        s0 = starts[0];
        pulse_a();
        repeat (50) @(negedge clk);
        check("no_start_while_forced", 32'(starts[0] - s0), 32'd0);
        check("busy_during_stall", 32'(bsy_a), 32'd1);
        force_busy = 1'b0;
        wait_done(0);
        repeat (5) @(negedge clk);
        check("single_done_stall", 32'(dones[0] - d0), 32'd1);

        // Asynchronous reset after the third byte, then a fresh run from address 0
        push_a();
        d0 = dones[0];
        pulse_a();
        t = 0;
        while (bytes_done[0] < 3 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("third_byte_timeout", 32'(t < TMO), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_txs", 32'(txs_a), 32'd0);
        check("arst_busy", 32'(bsy_a), 32'd0);
        check("arst_done", 32'(dn_a), 32'd0);
        check("arst_addr", 32'(addr_a), 32'd0);
        check("arst_txd", 32'(txd_a), 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", 32'(dones[0] - d0), 32'd0);
        push_a();
        pulse_a();
        wait_done(0);
        repeat (5) @(negedge clk);
        check("single_done_after_reset", 32'(dones[0] - d0), 32'd1);

        // 32-bit word, single-entry matrix
        push_b();
        d0 = dones[1];
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1);
        repeat (5) @(negedge clk);
        check("single_done_b", 32'(dones[1] - d0), 32'd1);
        check("addr_b_zero", 32'(addr_b), 32'd0);
        check("busy_b_low", 32'(bsy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
